// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16->16 multiply sequencer that borrows the shared ALU adder,
// and the ALU operand mux that arbitrates between the core and the sequencer.
module alu_mul_sequencer #(
    parameter bit         EARLY_EXIT = 1'b1,
    parameter logic [2:0] OP_ADD     = 3'b000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [15:0] i_mcand,
    input  logic [15:0] i_mplier,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_product,
    input  logic [15:0] i_coreSrc1,
    input  logic [15:0] i_coreSrc2,
    input  logic [2:0]  i_coreOpcode,
    input  logic        i_coreFlagBit,
    output logic        o_coreGrant,
    output logic [15:0] o_aluSrc1,
    output logic [15:0] o_aluSrc2,
    output logic [2:0]  o_aluOpcode,
    output logic        o_aluFlagBit,
    input  logic [15:0] i_aluResult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] mc_q, mc_d;
    logic [15:0] mp_q, mp_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] product_q, product_d;
    logic        last_s;
    logic [15:0] acc_next_s;

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= S_IDLE;
            acc_q     <= 16'd0;
            mc_q      <= 16'd0;
            mp_q      <= 16'd0;
            cnt_q     <= 4'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        mc_d       = mc_q;
        mp_d       = mp_q;
        cnt_d      = cnt_q;
        product_d  = product_q;
        // The product must include the add performed in the final RUN cycle.
        acc_next_s = mp_q[0] ? i_aluResult : acc_q;
        last_s     = (cnt_q == 4'd15) ||
                     ((EARLY_EXIT == 1'b1) && (mp_q[15:1] == 15'd0));
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    acc_d   = 16'd0;
                    mc_d    = i_mcand;
                    mp_d    = i_mplier;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d = acc_next_s;
                mc_d  = {mc_q[14:0], 1'b0};
                mp_d  = {1'b0, mp_q[15:1]};
                cnt_d = cnt_q + 4'd1;
                if (last_s) begin
                    state_d   = S_DONE;
                    product_d = acc_next_s;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy      = (state_q == S_RUN);
    assign o_done      = (state_q == S_DONE);
    assign o_product   = product_q;
    assign o_coreGrant = ~o_busy;

    // ALU operand mux: sequencer owns the adder only while running
    always_comb begin
        o_aluSrc1    = i_coreSrc1;
        o_aluSrc2    = i_coreSrc2;
        o_aluOpcode  = i_coreOpcode;
        o_aluFlagBit = i_coreFlagBit;
        if (state_q == S_RUN) begin
            o_aluSrc1    = acc_q;
            o_aluSrc2    = mc_q;
            o_aluOpcode  = OP_ADD;
            o_aluFlagBit = 1'b0;
        end else begin
            o_aluSrc1    = i_coreSrc1;
            o_aluSrc2    = i_coreSrc2;
            o_aluOpcode  = i_coreOpcode;
            o_aluFlagBit = i_coreFlagBit;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer: one early-exit and one fixed-length instance
// share stimulus; each gets its own behavioural ALU.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [15:0] mcand, mplier;
    logic [15:0] core_src1, core_src2;
    logic [2:0]  core_op;
    logic        core_flag;

    logic        busy1, done1, grant1, flag1;
    logic [15:0] prod1, src1_1, src2_1, res1;
    logic [2:0]  op1;
    logic        busy0, done0, grant0, flag0;
    logic [15:0] prod0, src1_0, src2_0, res0;
    logic [2:0]  op0;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int          n_early;
    } vec_t;

    vec_t vecs [7];

    alu_mul_sequencer #(.EARLY_EXIT(1'b1), .OP_ADD(3'b000)) u_ee (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_mcand(mcand), .i_mplier(mplier),
        .o_busy(busy1), .o_done(done1), .o_product(prod1),
        .i_coreSrc1(core_src1), .i_coreSrc2(core_src2), .i_coreOpcode(core_op),
        .i_coreFlagBit(core_flag), .o_coreGrant(grant1),
        .o_aluSrc1(src1_1), .o_aluSrc2(src2_1), .o_aluOpcode(op1), .o_aluFlagBit(flag1),
        .i_aluResult(res1)
    );

    alu_mul_sequencer #(.EARLY_EXIT(1'b0), .OP_ADD(3'b000)) u_fx (
        .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_mcand(mcand), .i_mplier(mplier),
        .o_busy(busy0), .o_done(done0), .o_product(prod0),
        .i_coreSrc1(core_src1), .i_coreSrc2(core_src2), .i_coreOpcode(core_op),
        .i_coreFlagBit(core_flag), .o_coreGrant(grant0),
        .o_aluSrc1(src1_0), .o_aluSrc2(src2_0), .o_aluOpcode(op0), .o_aluFlagBit(flag0),
        .i_aluResult(res0)
    );

    // Behavioural ALU: add for opcode 0, xor otherwise
    assign res1 = (op1 == 3'b000) ? (src1_1 + src2_1) : (src1_1 ^ src2_1);
    assign res0 = (op0 == 3'b000) ? (src1_0 + src2_0) : (src1_0 ^ src2_0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One multiply on both instances; checks latency, busy length and product
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_p, input int n1);
        int k, d1, d0, bc1, bc0;
        logic [15:0] p1, p0;
        d1 = 0; d0 = 0; bc1 = 0; bc0 = 0; p1 = 16'hxxxx; p0 = 16'hxxxx;
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k <= 40 && (d1 == 0 || d0 == 0)) begin
            if (busy1) bc1++;
            if (busy0) bc0++;
            if (done1 && d1 == 0) begin d1 = k; p1 = prod1; end
            if (done0 && d0 == 0) begin d0 = k; p0 = prod0; end
            if (d1 == 0 || d0 == 0) begin
                @(negedge clk);
                k++;
            end
        end
        chk($sformatf("ee_done_cycle %h*%h", a, b), d1, n1 + 1);
        chk($sformatf("ee_busy_len %h*%h", a, b), bc1, n1);
        chk($sformatf("ee_product %h*%h", a, b), p1, exp_p);
        chk($sformatf("fx_done_cycle %h*%h", a, b), d0, 17);
        chk($sformatf("fx_busy_len %h*%h", a, b), bc0, 16);
        chk($sformatf("fx_product %h*%h", a, b), p0, exp_p);
    endtask

    initial begin
        int dcount;
        vecs[0] = '{16'd3,    16'd5,    16'd15,   3};
        vecs[1] = '{16'h1234, 16'h0000, 16'h0000, 1};
        vecs[2] = '{16'hFFFF, 16'h8003, 16'h7FFD, 16};
        vecs[3] = '{16'hFFFD, 16'h0007, 16'hFFEB, 3};
        vecs[4] = '{16'h00FF, 16'h0100, 16'hFF00, 9};
        vecs[5] = '{16'h1234, 16'h0001, 16'h1234, 1};
        vecs[6] = '{16'h0002, 16'h8000, 16'h0000, 16};

        rstn = 1'b0; start = 1'b0; mcand = 16'd0; mplier = 16'd0;
        core_src1 = 16'h00FF; core_src2 = 16'h0F0F; core_op = 3'b011; core_flag = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_product", prod1, 16'h0000);
        chk("rst_grant", grant1, 1'b1);
        rstn = 1'b1;
        @(negedge clk);

        chk("idle_src1", src1_1, 16'h00FF);
        chk("idle_src2", src2_1, 16'h0F0F);
        chk("idle_op", op1, 3'b011);
        chk("idle_flag", flag1, 1'b1);
        chk("idle_grant", grant1, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].n_early);
        end

        // Mux ownership during RUN: acc/mc shown, core locked out
        @(negedge clk);
        mcand = 16'd3; mplier = 16'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("run1_src1", src1_1, 16'd0);
        chk("run1_src2", src2_1, 16'd3);
        chk("run1_op", op1, 3'b000);
        chk("run1_flag", flag1, 1'b0);
        chk("run1_grant", grant1, 1'b0);
        @(negedge clk);
        chk("run2_src1", src1_1, 16'd3);
        chk("run2_src2", src2_1, 16'd6);

        // Reset in cycle 5 of a 16-cycle op: prior product is nonzero
        do_reset();
        run_op(16'hFFFF, 16'h8003, 16'h7FFD, 16);
        @(negedge clk);
        mcand = 16'hFFFF; mplier = 16'h8003; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before_rst", busy0, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_product", prod0, 16'h0000);
        chk("mid_rst_grant", grant0, 1'b1);
        @(negedge clk);
        rstn = 1'b1;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done0 || done1) dcount++;
        end
        chk("mid_rst_no_done", dcount, 0);
        run_op(16'd3, 16'd5, 16'd15, 3);

        // Start held high: ignored in RUN, relatched in DONE, product held across new RUN
        do_reset();
        @(negedge clk);
        mcand = 16'd3; mplier = 16'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mcand = 16'd4; mplier = 16'd3;
        for (int k = 1; k <= 7; k++) begin
            chk($sformatf("hold_busy k=%0d", k), busy1,
                (k == 1 || k == 2 || k == 3 || k == 5 || k == 6) ? 1'b1 : 1'b0);
            chk($sformatf("hold_done k=%0d", k), done1, (k == 4 || k == 7) ? 1'b1 : 1'b0);
            chk($sformatf("hold_product k=%0d", k), prod1,
                (k < 4) ? 16'd0 : ((k < 7) ? 16'd15 : 16'd12));
            if (k < 7) @(negedge clk);
        end
        start = 1'b0;
        do_reset();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
